// File: rtl/hp_rdma_pkg.sv
// Shared constants and types for the HP-port read DMA lane router.
package hp_rdma_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4KB        = 4096;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
  localparam int         AXI_ID_W       = 4;

  typedef enum logic [2:0] {IDLE, CALC, AR, R, NEXT, DONE} state_t;

  function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/hp_rdma_lane_router_if.sv
// AXI4 read-address / read-data channel bundle used by the lane router.
interface hp_rdma_lane_router_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  logic                             arvalid;
  logic                             arready;
  logic [ADDR_W-1:0]                araddr;
  logic [7:0]                       arlen;
  logic [2:0]                       arsize;
  logic [1:0]                       arburst;
  logic [hp_rdma_pkg::AXI_ID_W-1:0] arid;
  logic [3:0]                       arcache;
  logic [2:0]                       arprot;
  logic [3:0]                       arqos;
  logic                             rvalid;
  logic                             rready;
  logic [DATA_W-1:0]                rdata;
  logic                             rlast;
  logic [1:0]                       rresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, arcache, arprot, arqos, rready,
    input  arready, rvalid, rdata, rlast, rresp
  );
  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, arcache, arprot, arqos, rready,
    output arready, rvalid, rdata, rlast, rresp
  );
endinterface

// File: rtl/hp_lane_fifo.sv
// Synchronous show-ahead FIFO for one lane; head word is visible whenever valid is high.
module hp_lane_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_pop;

  assign valid  = (count_q != '0);
  assign do_pop = pop && valid;
  assign count  = count_q;
  // Gate the head so an empty lane reads as zero rather than stale storage.
  assign rdata  = valid ? mem[rd_ptr_q] : '0;

  // Pushes arrive only against reserved credit, so no full check is needed here.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/hp_rdma_lane_router.sv
// Strided 2-D tile read DMA: credit-checked, 4KB-safe AXI bursts routed row-round-robin into lane FIFOs.
// Optional HP_RDMA_PERF_EN adds perf_beats / perf_stall saturating counters.
module hp_rdma_lane_router
  import hp_rdma_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int NUM_LANES  = 12,
  parameter int LANE_DEPTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic [ADDR_W-1:0]                cfg_base_addr,
  input  logic [ADDR_W-1:0]                cfg_row_stride,
  input  logic [15:0]                      cfg_row_beats,
  input  logic [15:0]                      cfg_num_rows,
  input  logic [$clog2(NUM_LANES+1)-1:0]   cfg_lanes_used,
  output logic                             busy,
  output logic                             done,
  output logic                             rresp_err,
  hp_rdma_lane_router_if.master            m_axi,
  output logic [NUM_LANES-1:0]             lane_valid,
  output logic [NUM_LANES*DATA_W-1:0]      lane_data,
  input  logic [NUM_LANES-1:0]             lane_ready
`ifdef HP_RDMA_PERF_EN
  ,
  output logic [31:0]                      perf_beats,
  output logic [31:0]                      perf_stall
`endif
);
  localparam int LW  = $clog2(NUM_LANES+1);
  localparam int CW  = $clog2(LANE_DEPTH) + 1;
  localparam int BSH = $clog2(DATA_W/8);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d, stride_q, stride_d;
  logic [15:0]       row_beats_q, row_beats_d, beats_left_q, beats_left_d, rows_left_q, rows_left_d;
  logic [LW-1:0]     lanes_used_q, lanes_used_d, lane_ptr_q, lane_ptr_d;
  logic [8:0]        len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]     resv_q, resv_d;
  logic              err_q, err_d;

  logic [NUM_LANES-1:0][CW-1:0]     lane_cnt;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_dout;
  logic [NUM_LANES-1:0]             push;
  logic [12:0]                      bytes_to_4k;
  logic [16:0]                      len_c;
  logic                             fits, r_beat, last_beat, row_end;

  assign bytes_to_4k = 13'(AXI_4KB) - {1'b0, addr_q[11:0]};
  assign len_c = min17(min17(17'(MAX_BURST), {1'b0, beats_left_q}), 17'(bytes_to_4k >> BSH));
  assign fits  = (17'(lane_cnt[lane_ptr_q]) + 17'(resv_q) + len_c) <= 17'(LANE_DEPTH);
  assign r_beat    = (state_q == R) && m_axi.rvalid;
  assign last_beat = (beat_cnt_q == len_q - 9'd1);
  assign row_end   = (beats_left_q == {7'd0, len_q});
  assign push      = r_beat ? (NUM_LANES'(1) << lane_ptr_q) : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    hp_lane_fifo #(.DATA_W(DATA_W), .DEPTH(LANE_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .wdata (m_axi.rdata),
      .pop   (lane_ready[i]),
      .rdata (lane_dout[i]),
      .valid (lane_valid[i]),
      .count (lane_cnt[i])
    );
  end
  assign lane_data = lane_dout;

  assign m_axi.arvalid = (state_q == AR);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'(len_q - 9'd1);
  assign m_axi.arsize  = 3'(BSH);
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arid    = '0;
  assign m_axi.arcache = AXI_CACHE_MOD;
  assign m_axi.arprot  = '0;
  assign m_axi.arqos   = '0;
  assign m_axi.rready  = (state_q == R);
  assign busy      = (state_q inside {CALC, AR, R, NEXT});
  assign done      = (state_q == DONE);
  assign rresp_err = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_base_d   = row_base_q;
    stride_d     = stride_q;
    row_beats_d  = row_beats_q;
    beats_left_d = beats_left_q;
    rows_left_d  = rows_left_q;
    lanes_used_d = lanes_used_q;
    lane_ptr_d   = lane_ptr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    resv_d       = resv_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: if (cfg_start) begin
        addr_d       = cfg_base_addr;
        row_base_d   = cfg_base_addr;
        stride_d     = cfg_row_stride;
        row_beats_d  = cfg_row_beats;
        beats_left_d = cfg_row_beats;
        rows_left_d  = cfg_num_rows;
        lanes_used_d = cfg_lanes_used;
        lane_ptr_d   = '0;
        err_d        = 1'b0;
        state_d      = CALC;
      end
      CALC: if (fits) begin
        len_d      = len_c[8:0];
        resv_d     = CW'(len_c);
        beat_cnt_d = '0;
        state_d    = AR;
      end
      AR: if (m_axi.arready) state_d = R;
      // Burst length is owned by the beat counter; RLAST only flags disagreement.
      R: if (r_beat) begin
        beat_cnt_d = beat_cnt_q + 9'd1;
        resv_d     = resv_q - CW'(1);
        if (m_axi.rresp != AXI_RESP_OKAY || m_axi.rlast != last_beat) err_d = 1'b1;
        if (last_beat) state_d = NEXT;
      end
      NEXT: begin
        state_d = CALC;
        if (row_end) begin
          row_base_d   = row_base_q + stride_q;
          addr_d       = row_base_q + stride_q;
          beats_left_d = row_beats_q;
          rows_left_d  = rows_left_q - 16'd1;
          lane_ptr_d   = (lane_ptr_q + LW'(1) == lanes_used_q) ? '0 : lane_ptr_q + LW'(1);
          if (rows_left_q == 16'd1) state_d = DONE;
        end else begin
          addr_d       = addr_q + (ADDR_W'(len_q) << BSH);
          beats_left_d = beats_left_q - {7'd0, len_q};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      row_beats_q  <= '0;
      beats_left_q <= '0;
      rows_left_q  <= '0;
      lanes_used_q <= '0;
      lane_ptr_q   <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      resv_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      stride_q     <= stride_d;
      row_beats_q  <= row_beats_d;
      beats_left_q <= beats_left_d;
      rows_left_q  <= rows_left_d;
      lanes_used_q <= lanes_used_d;
      lane_ptr_q   <= lane_ptr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      resv_q       <= resv_d;
      err_q        <= err_d;
    end
  end

`ifdef HP_RDMA_PERF_EN
  logic [31:0] perf_beats_q, perf_beats_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_beats_d = perf_beats_q;
    perf_stall_d = perf_stall_q;
    if (state_q == IDLE && cfg_start) begin
      perf_beats_d = '0;
      perf_stall_d = '0;
    end else begin
      if (r_beat && perf_beats_q != '1) perf_beats_d = perf_beats_q + 32'd1;
      if (state_q == CALC && !fits && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_beats_q <= perf_beats_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_beats = perf_beats_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_hp_rdma_lane_router.sv
// Scoreboard bench: address-keyed AXI slave, per-lane expected data built from row/lane rules.
module tb_hp_rdma_lane_router;
  localparam int DW = 64, AW = 32, NL = 12, DEP = 64, MB = 16, LW = 4, QD = 1024;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0, cfg_row_stride = '0;
  logic [15:0]   cfg_row_beats = '0, cfg_num_rows = '0;
  logic [LW-1:0] cfg_lanes_used = '0;
  logic          busy, done, rresp_err;
  logic [NL-1:0] lane_valid, lane_ready;
  logic [NL*DW-1:0] lane_data;
`ifdef HP_RDMA_PERF_EN
  logic [31:0] perf_beats, perf_stall;
`endif

  hp_rdma_lane_router_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  hp_rdma_lane_router #(.DATA_W(DW), .ADDR_W(AW), .NUM_LANES(NL), .LANE_DEPTH(DEP), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_row_stride(cfg_row_stride), .cfg_row_beats(cfg_row_beats), .cfg_num_rows(cfg_num_rows),
    .cfg_lanes_used(cfg_lanes_used), .busy(busy), .done(done), .rresp_err(rresp_err),
    .m_axi(axi), .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready)
`ifdef HP_RDMA_PERF_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;

  int n_cmp = 0, n_bad = 0;
  ar_t exp_ar[$];
  ar_t sl_q[$];
  logic [DW-1:0] exp_mem [NL][QD];
  int wr_i[NL], rd_i[NL];
  int lanes_cur = NL, err_beat = -1, gbeat = 0, ar_cnt = 0, done_cnt = 0, viol = 0, rdy_mode = 1;
  bit fast = 1'b1;

  function automatic logic [DW-1:0] f_data(input logic [31:0] a);
    return {a ^ 32'h5A5A_A5A5, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit drained();
    for (int i = 0; i < NL; i++) if (rd_i[i] < wr_i[i]) return 1'b0;
    return 1'b1;
  endfunction

  // AXI slave: one burst at a time, data derived from the beat address.
  initial begin
    bit ar_hs, r_hs;
    ar_t cap;
    int sl_k;
    sl_k = 0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      cap.addr = axi.araddr; cap.len = axi.arlen;
      @(posedge clk); #1;
      if (ar_hs) sl_q.push_back(cap);
      if (r_hs) begin
        sl_k++; gbeat++;
        if (sl_k > int'(sl_q[0].len)) begin void'(sl_q.pop_front()); sl_k = 0; end
      end
      axi.arready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!(axi.rvalid && !r_hs)) begin
        if (sl_q.size() > 0 && (fast || $urandom_range(0, 3) != 0)) begin
          axi.rvalid = 1'b1;
          axi.rdata  = f_data(sl_q[0].addr + 32'(sl_k * 8));
          axi.rlast  = (sl_k == int'(sl_q[0].len));
          axi.rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        end
      end
    end
  end

  initial begin
    lane_ready = '0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       lane_ready = '0;
        1:       lane_ready = '1;
        default: lane_ready = NL'($urandom);
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands something over.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (axi.arvalid && axi.arready) begin
          ar_t e;
          ar_cnt++;
          e = (exp_ar.size() > 0) ? exp_ar.pop_front() : '{addr: 32'hDEAD_BEEF, len: 8'hFF};
          chk("ar_addr", 64'(axi.araddr), 64'(e.addr));
          chk("ar_len", 64'(axi.arlen), 64'(e.len));
          chk("ar_const", 64'({axi.arsize, axi.arburst, axi.arid, axi.arcache, axi.arprot, axi.arqos}),
              64'({3'd3, 2'b01, 4'd0, 4'b0011, 3'd0, 4'd0}));
        end
        for (int i = 0; i < NL; i++) begin
          if (lane_valid[i] && i >= lanes_cur) viol++;
          else if (lane_valid[i] && lane_ready[i]) begin
            logic [DW-1:0] e;
            e = (rd_i[i] < wr_i[i]) ? exp_mem[i][rd_i[i]] : {DW{1'b1}};
            rd_i[i]++;
            chk($sformatf("lane%0d_data", i), lane_data[i*DW +: DW], e);
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic run(input logic [31:0] base, input logic [31:0] stride, input int beats,
                     input int rows, input int lanes, input int ebeat, input int stall);
    logic [31:0] a, rb;
    int rem, len, b4, ln, t;
    ar_t e;
    for (int i = 0; i < NL; i++) begin wr_i[i] = 0; rd_i[i] = 0; end
    for (int r = 0; r < rows; r++) begin
      rb = base + 32'(r) * stride;
      ln = r % lanes;
      for (int k = 0; k < beats; k++) begin
        exp_mem[ln][wr_i[ln]] = f_data(rb + 32'(k * 8));
        wr_i[ln]++;
      end
      a = rb; rem = beats;
      while (rem > 0) begin
        b4  = (4096 - int'(a[11:0])) / 8;
        len = (rem < MB) ? rem : MB;
        if (b4 < len) len = b4;
        e.addr = a; e.len = 8'(len - 1);
        exp_ar.push_back(e);
        a = a + 32'(len * 8); rem -= len;
      end
    end
    lanes_cur = lanes; err_beat = ebeat; gbeat = 0; ar_cnt = 0; done_cnt = 0; viol = 0;
    rdy_mode = (stall > 0) ? 0 : (fast ? 1 : 2);
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_row_stride = stride; cfg_row_beats = 16'(beats);
    cfg_num_rows = 16'(rows); cfg_lanes_used = LW'(lanes); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared_on_start", 64'(rresp_err), 64'd0);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      @(negedge clk);
      chk("stall_ar_cnt", 64'(ar_cnt), 64'(DEP / MB));
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_lane_full", 64'(lane_valid[0]), 64'd1);
      rdy_mode = 2;
    end
    t = 0;
    while (!done && t < 5000) begin @(negedge clk); t++; end
    chk("done_seen", 64'(t < 5000), 64'd1);
`ifdef HP_RDMA_PERF_EN
    chk("perf_beats", 64'(perf_beats), 64'(beats * rows));
`endif
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    t = 0;
    while (!drained() && t < 5000) begin @(negedge clk); t++; end
    chk("lanes_drained", 64'(drained()), 64'd1);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("ar_remaining", 64'(exp_ar.size()), 64'd0);
    chk("rresp_err", 64'(rresp_err), 64'(ebeat >= 0 && ebeat < beats * rows));
    chk("unused_lanes_quiet", 64'(viol), 64'd0);
    exp_ar.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy_done_err", 64'({busy, done, rresp_err}), 64'd0);
    chk("rst_lane_valid", 64'(lane_valid), 64'd0);
    chk("rst_arvalid_rready", 64'({axi.arvalid, axi.rready}), 64'd0);

    fast = 1'b1;
    run(32'h0000_1000, 32'h100, 8, 3, 3, -1, 0);
    fast = 1'b0;
    run(32'h0000_2000, 32'h400, 40, 12, 12, -1, 0);
    run(32'h0000_0FE0, 32'h0, 16, 1, 1, -1, 0);
    run(32'h0001_0000, 32'h0, 128, 1, 1, -1, 300);
    run(32'h0000_3000, 32'h80, 4, 5, 2, -1, 0);
    run(32'h0000_4000, 32'h40, 8, 2, 2, 5, 0);
    run(32'h0000_5000, 32'h40, 8, 2, 2, -1, 0);
    for (int n = 0; n < 4; n++)
      run($urandom & 32'hFFFF_FFF8, 32'($urandom_range(0, 2048) * 8), $urandom_range(1, 40),
          $urandom_range(1, 14), $urandom_range(1, NL), -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
